// File: rtl/instr_fetch_reader.sv
// Instruction fetch reader: reads 16-bit words at the PC, assembles 16/32-bit
// instructions into the IF/ID register and steers the PC register.
module instr_fetch_reader #(
    parameter int unsigned  ADDR_W   = 20,
    parameter logic [31:0]  RESET_PC = 32'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       current_count,
    output logic [31:0]       next_count,
    output logic              pc_stall,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              id_stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_target,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid
);

    localparam logic [1:0] FIRST = 2'd0;
    localparam logic [1:0] LO    = 2'd1;
    localparam logic [1:0] HI    = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] hi_buf_q, hi_buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;

    logic [31:0] pc_plus1;
    logic [31:0] pc_plus2;

    assign pc_plus1 = current_count + 32'd1;
    assign pc_plus2 = current_count + 32'd2;

    always_comb begin
        next_count    = current_count;
        pc_stall      = 1'b1;
        mem_en        = 1'b0;
        mem_addr      = current_count[ADDR_W-1:0];
        state_d       = state_q;
        hi_buf_d      = hi_buf_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (redirect) begin
            next_count    = redirect_target;
            pc_stall      = 1'b0;
            instr_valid_d = 1'b0;
            hi_buf_d      = '0;
            state_d       = FIRST;
        end else if (!id_stall) begin
            // The PC only moves once an instruction completes, so in HI the
            // current count still names the first word of the 32-bit pair.
            case (state_q)
                FIRST: begin
                    mem_en        = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = LO;
                end
                LO: begin
                    mem_en   = 1'b1;
                    mem_addr = pc_plus1[ADDR_W-1:0];
                    if (!mem_rdata[15]) begin
                        instr_d       = {16'h0, mem_rdata};
                        instr_pc_d    = current_count;
                        instr_valid_d = 1'b1;
                        next_count    = pc_plus1;
                        pc_stall      = 1'b0;
                    end else begin
                        hi_buf_d      = mem_rdata;
                        instr_valid_d = 1'b0;
                        state_d       = HI;
                    end
                end
                HI: begin
                    mem_en        = 1'b1;
                    mem_addr      = pc_plus2[ADDR_W-1:0];
                    instr_d       = {hi_buf_q, mem_rdata};
                    instr_pc_d    = current_count;
                    instr_valid_d = 1'b1;
                    next_count    = pc_plus2;
                    pc_stall      = 1'b0;
                    state_d       = LO;
                end
                default: begin
                    instr_valid_d = 1'b0;
                    state_d       = FIRST;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FIRST;
            hi_buf_q      <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hi_buf_q      <= hi_buf_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_reader.sv
// Directed bench for instr_fetch_reader with a PC register and synchronous
// memory modelled locally; a second instance checks narrow address wrap.
module tb_instr_fetch_reader;

    logic        clk;
    logic        rst;
    logic        rst4;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_target;

    logic [31:0] pc;
    logic [31:0] next_count;
    logic        pc_stall;
    logic        mem_en;
    logic [19:0] mem_addr;
    logic [15:0] rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [15:0] mem [256];

    logic [31:0] pc4;
    logic [31:0] next_count4;
    logic        pc_stall4;
    logic        mem_en4;
    logic [3:0]  mem_addr4;
    logic [15:0] rdata4;
    logic [31:0] instr4;
    logic [31:0] instr_pc4;
    logic        instr_valid4;
    logic [15:0] mem4 [16];

    int n_total;
    int n_bad;

    instr_fetch_reader #(.ADDR_W(20), .RESET_PC(32'h20)) dut (
        .clk             (clk),
        .reset           (rst),
        .current_count   (pc),
        .next_count      (next_count),
        .pc_stall        (pc_stall),
        .mem_en          (mem_en),
        .mem_addr        (mem_addr),
        .mem_rdata       (rdata),
        .id_stall        (id_stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid)
    );

    instr_fetch_reader #(.ADDR_W(4), .RESET_PC(32'h1F)) dut4 (
        .clk             (clk),
        .reset           (rst4),
        .current_count   (pc4),
        .next_count      (next_count4),
        .pc_stall        (pc_stall4),
        .mem_en          (mem_en4),
        .mem_addr        (mem_addr4),
        .mem_rdata       (rdata4),
        .id_stall        (1'b0),
        .redirect        (1'b0),
        .redirect_target (32'h0),
        .instr           (instr4),
        .instr_pc        (instr_pc4),
        .instr_valid     (instr_valid4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) pc <= 32'h20;
        else if (!pc_stall) pc <= next_count;
    end

    always @(posedge clk) begin
        if (mem_en) rdata <= mem[mem_addr[7:0]];
    end

    always @(posedge clk or posedge rst4) begin
        if (rst4) pc4 <= 32'h1F;
        else if (!pc_stall4) pc4 <= next_count4;
    end

    always @(posedge clk) begin
        if (mem_en4) rdata4 <= mem4[mem_addr4];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        rst = 1'b1;
        rst4 = 1'b1;
        id_stall = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;
        rdata = '0;
        rdata4 = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        for (int i = 0; i < 16; i++) mem4[i] = 16'h0;
        mem[8'h20] = 16'h1234;
        mem[8'h21] = 16'h8005;
        mem[8'h22] = 16'hBEEF;
        mem[8'h23] = 16'h0042;
        mem[8'h24] = 16'h0011;
        mem[8'h40] = 16'h0007;
        mem[8'h41] = 16'h0008;
        mem4[4'hF] = 16'h9ABC;
        mem4[4'h0] = 16'h5555;

        repeat (2) tick();
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);

        rst = 1'b0;
        #1;
        check("first_en", {31'b0, mem_en}, 32'h1);
        check("first_addr", {12'b0, mem_addr}, 32'h20);
        check("first_stall", {31'b0, pc_stall}, 32'h1);
        check("first_next", next_count, 32'h20);

        tick();
        check("lo1_valid", {31'b0, instr_valid}, 32'h0);
        check("lo1_next", next_count, 32'h21);
        check("lo1_stall", {31'b0, pc_stall}, 32'h0);
        check("lo1_addr", {12'b0, mem_addr}, 32'h21);

        tick();
        check("i1_instr", instr, 32'h0000_1234);
        check("i1_pc", instr_pc, 32'h20);
        check("i1_valid", {31'b0, instr_valid}, 32'h1);
        check("lo32_stall", {31'b0, pc_stall}, 32'h1);
        check("lo32_addr", {12'b0, mem_addr}, 32'h22);

        tick();
        check("hi_valid", {31'b0, instr_valid}, 32'h0);
        id_stall = 1'b1;
        #1;
        check("stall_en", {31'b0, mem_en}, 32'h0);
        check("stall_pcst", {31'b0, pc_stall}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", {31'b0, instr_valid}, 32'h0);
            check("stall_instr", instr, 32'h0000_1234);
            check("stall_ipc", instr_pc, 32'h20);
            check("stall_en2", {31'b0, mem_en}, 32'h0);
        end
        id_stall = 1'b0;
        #1;
        check("hi_next", next_count, 32'h23);
        check("hi_stall", {31'b0, pc_stall}, 32'h0);
        check("hi_addr", {12'b0, mem_addr}, 32'h23);

        tick();
        check("i2_instr", instr, 32'h8005_BEEF);
        check("i2_pc", instr_pc, 32'h21);
        check("i2_valid", {31'b0, instr_valid}, 32'h1);
        check("i3_next", next_count, 32'h24);

        tick();
        check("i3_instr", instr, 32'h0000_0042);
        check("i3_pc", instr_pc, 32'h23);
        redirect = 1'b1;
        redirect_target = 32'h40;
        #1;
        check("rd_next", next_count, 32'h40);
        check("rd_stall", {31'b0, pc_stall}, 32'h0);
        check("rd_en", {31'b0, mem_en}, 32'h0);

        tick();
        redirect = 1'b0;
        check("rd_valid", {31'b0, instr_valid}, 32'h0);
        #1;
        check("rd_first_addr", {12'b0, mem_addr}, 32'h40);
        check("rd_first_en", {31'b0, mem_en}, 32'h1);

        tick();
        check("rd_lo_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        check("rd_instr", instr, 32'h0000_0007);
        check("rd_pc", instr_pc, 32'h40);
        check("rd_ivalid", {31'b0, instr_valid}, 32'h1);

        redirect = 1'b1;
        id_stall = 1'b1;
        redirect_target = 32'h21;
        #1;
        check("rds_stall", {31'b0, pc_stall}, 32'h0);
        check("rds_next", next_count, 32'h21);
        check("rds_en", {31'b0, mem_en}, 32'h0);

        tick();
        redirect = 1'b0;
        id_stall = 1'b0;
        check("rds_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        check("rds_lo_stall", {31'b0, pc_stall}, 32'h1);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_pc", instr_pc, 32'h0);
        check("mid_rst_valid", {31'b0, instr_valid}, 32'h0);

        tick();
        rst = 1'b0;
        tick();
        check("restart_valid0", {31'b0, instr_valid}, 32'h0);
        tick();
        check("restart_instr", instr, 32'h0000_1234);
        check("restart_pc", instr_pc, 32'h20);
        check("restart_valid", {31'b0, instr_valid}, 32'h1);

        rst4 = 1'b0;
        #1;
        check("w_first_addr", {28'b0, mem_addr4}, 32'hF);
        tick();
        check("w_lo_en", {31'b0, mem_en4}, 32'h1);
        check("w_lo_addr", {28'b0, mem_addr4}, 32'h0);
        check("w_lo_stall", {31'b0, pc_stall4}, 32'h1);
        tick();
        check("w_hi_next", next_count4, 32'h21);
        check("w_hi_stall", {31'b0, pc_stall4}, 32'h0);
        check("w_hi_addr", {28'b0, mem_addr4}, 32'h1);
        tick();
        check("w_instr", instr4, 32'h9ABC_5555);
        check("w_pc", instr_pc4, 32'h1F);
        check("w_valid", {31'b0, instr_valid4}, 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
